memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage_pkg.sv | 17 +
 rtl/memory_access_stage_writeback_register.sv | 37 +++
 rtl/memory_access_stage.sv | 161 ++++++++++++++++
 tb/tb_memory_access_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline definitions: word and register-address widths plus the
// control-signal encodings carried between pipeline stages.
package general_defs;

  localparam int WORD       = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic {MEM_READ_DISABLE  = 1'b0, MEM_READ  = 1'b1} mem_read_signal;
  typedef enum logic {MEM_WRITE_DISABLE = 1'b0, MEM_WRITE = 1'b1} mem_write_signal;
  typedef enum logic {NO_WRITE          = 1'b0, WRITE     = 1'b1} reg_file_write_sig;
  typedef enum logic {DATA_FROM_ALU     = 1'b0, DATA_FROM_MEM = 1'b1} reg_file_data_source;

  function automatic logic is_word_aligned(input logic [WORD-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/memory_access_stage_writeback_register.sv
// MEM/WB pipeline register. A bubble clears the valid and write-enable bits
// while leaving the payload fields untouched.
module memory_writeback_register
  import general_defs::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  bubble_i,
  input  reg_file_write_sig     reg_file_write_en_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       reg_data_i,
  output logic                  is_valid_o,
  output reg_file_write_sig     reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       reg_data_o
);

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      is_valid_o          <= 1'b0;
      reg_file_write_en_o <= NO_WRITE;
      reg_dest_addr_o     <= '0;
      reg_data_o          <= '0;
    end else if (bubble_i) begin
      is_valid_o          <= 1'b0;
      reg_file_write_en_o <= NO_WRITE;
    end else begin
      is_valid_o          <= 1'b1;
      reg_file_write_en_o <= reg_file_write_en_i;
      reg_dest_addr_o     <= reg_dest_addr_i;
      reg_data_o          <= reg_data_i;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// stalls upstream until it completes, and abandons reads that never answer.
module memory_access_stage
  import general_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  is_valid_i,
  input  mem_read_signal        mem_read_en_i,
  input  mem_write_signal       mem_write_en_i,
  input  reg_file_write_sig     reg_file_write_en_i,
  input  reg_file_data_source   reg_file_data_source_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       reg_2_data_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [WORD-1:0]       dmem_addr_o,
  output logic [WORD-1:0]       dmem_wdata_o,
  input  logic                  dmem_ready_i,
  input  logic                  dmem_rvalid_i,
  input  logic [WORD-1:0]       dmem_rdata_i,
  output logic                  is_valid_o,
  output reg_file_write_sig     reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       reg_data_o,
  output logic                  fault_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                  state, next_state;
  logic [CNT_W-1:0]        timeout_cnt;
  logic [WORD-1:0]         cap_addr, cap_wdata;
  logic                    cap_we;
  reg_file_write_sig       cap_rf_we;
  reg_file_data_source     cap_src;
  logic [ADDR_WIDTH-1:0]   cap_dest;
  logic                    fault_q;

  logic                    stall, capture, cnt_clear, cnt_inc, fault_d, wb_bubble;
  reg_file_write_sig       wb_rf_we;
  logic [ADDR_WIDTH-1:0]   wb_dest;
  logic [WORD-1:0]         wb_data;

  wire mem_op = is_valid_i && (mem_read_en_i == MEM_READ || mem_write_en_i == MEM_WRITE);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    capture    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    fault_d    = 1'b0;
    wb_bubble  = 1'b1;
    wb_rf_we   = cap_rf_we;
    wb_dest    = cap_dest;
    wb_data    = cap_addr;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          if (is_word_aligned(alu_result_i)) begin
            stall      = 1'b1;
            capture    = 1'b1;
            next_state = REQ;
          end else begin
            fault_d = 1'b1;
          end
        end else if (is_valid_i) begin
          wb_bubble = 1'b0;
          wb_rf_we  = reg_file_write_en_i;
          wb_dest   = reg_dest_addr_i;
          wb_data   = alu_result_i;
        end
      end
      REQ: begin
        if (dmem_ready_i && cap_we) begin
          wb_bubble  = 1'b0;
          next_state = IDLE;
        end else if (dmem_ready_i) begin
          stall      = 1'b1;
          cnt_clear  = 1'b1;
          next_state = WAIT;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT: begin
        // A response arriving on the final allowed cycle still completes the load.
        if (dmem_rvalid_i) begin
          wb_bubble  = 1'b0;
          wb_data    = (cap_src == DATA_FROM_MEM) ? dmem_rdata_i : cap_addr;
          next_state = IDLE;
        end else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d    = 1'b1;
          next_state = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      timeout_cnt <= '0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_we      <= 1'b0;
      cap_rf_we   <= NO_WRITE;
      cap_src     <= DATA_FROM_ALU;
      cap_dest    <= '0;
      fault_q     <= 1'b0;
    end else begin
      state   <= next_state;
      fault_q <= fault_d;
      if (cnt_clear)    timeout_cnt <= '0;
      else if (cnt_inc) timeout_cnt <= timeout_cnt + CNT_W'(1);
      if (capture) begin
        cap_addr  <= alu_result_i;
        cap_wdata <= reg_2_data_i;
        cap_we    <= (mem_write_en_i == MEM_WRITE);
        cap_rf_we <= reg_file_write_en_i;
        cap_src   <= reg_file_data_source_i;
        cap_dest  <= reg_dest_addr_i;
      end
    end
  end

  memory_writeback_register u_mem_wb (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .bubble_i            (wb_bubble),
    .reg_file_write_en_i (wb_rf_we),
    .reg_dest_addr_i     (wb_dest),
    .reg_data_i          (wb_data),
    .is_valid_o          (is_valid_o),
    .reg_file_write_en_o (reg_file_write_en_o),
    .reg_dest_addr_o     (reg_dest_addr_o),
    .reg_data_o          (reg_data_o)
  );

  // Stall is decoded from live inputs, so it is forced low while reset is held.
  assign stall_o      = stall && reset_i;
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = (state == REQ) && cap_we;
  assign dmem_addr_o  = cap_addr;
  assign dmem_wdata_o = cap_wdata;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios followed by
// random operations predicted per instruction from cycle-count rules.
module tb_memory_access_stage;
  import general_defs::*;

  localparam int TIMEOUT = 16;

  typedef enum int {K_BUBBLE, K_ALU, K_LOAD, K_STORE} kind_e;

  logic                  clk_i   = 1'b0;
  logic                  reset_i = 1'b0;
  logic                  is_valid_i = 1'b0;
  mem_read_signal        mem_read_en_i = MEM_READ_DISABLE;
  mem_write_signal       mem_write_en_i = MEM_WRITE_DISABLE;
  reg_file_write_sig     reg_file_write_en_i = NO_WRITE;
  reg_file_data_source   reg_file_data_source_i = DATA_FROM_ALU;
  logic [ADDR_WIDTH-1:0] reg_dest_addr_i = '0;
  logic [WORD-1:0]       alu_result_i = '0;
  logic [WORD-1:0]       reg_2_data_i = '0;
  logic                  dmem_ready_i = 1'b0;
  logic                  dmem_rvalid_i = 1'b0;
  logic [WORD-1:0]       dmem_rdata_i = '0;

  logic                  stall_o, dmem_req_o, dmem_we_o, is_valid_o, fault_o;
  logic [WORD-1:0]       dmem_addr_o, dmem_wdata_o, reg_data_o;
  reg_file_write_sig     reg_file_write_en_o;
  logic [ADDR_WIDTH-1:0] reg_dest_addr_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  memory_access_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .is_valid_i             (is_valid_i),
    .mem_read_en_i          (mem_read_en_i),
    .mem_write_en_i         (mem_write_en_i),
    .reg_file_write_en_i    (reg_file_write_en_i),
    .reg_file_data_source_i (reg_file_data_source_i),
    .reg_dest_addr_i        (reg_dest_addr_i),
    .alu_result_i           (alu_result_i),
    .reg_2_data_i           (reg_2_data_i),
    .stall_o                (stall_o),
    .dmem_req_o             (dmem_req_o),
    .dmem_we_o              (dmem_we_o),
    .dmem_addr_o            (dmem_addr_o),
    .dmem_wdata_o           (dmem_wdata_o),
    .dmem_ready_i           (dmem_ready_i),
    .dmem_rvalid_i          (dmem_rvalid_i),
    .dmem_rdata_i           (dmem_rdata_i),
    .is_valid_o             (is_valid_o),
    .reg_file_write_en_o    (reg_file_write_en_o),
    .reg_dest_addr_o        (reg_dest_addr_o),
    .reg_data_o             (reg_data_o),
    .fault_o                (fault_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One instruction presented and held until the stage lets it go. The cycle
  // count follows from the rules: 1 cycle in IDLE, rd+1 cycles in REQ, and for
  // a load d+1 WAIT cycles, capped at TIMEOUT when no response comes.
  task automatic run_op(input kind_e kind, input logic [ADDR_WIDTH-1:0] dest,
                        input logic [WORD-1:0] alu, input logic [WORD-1:0] wdata,
                        input logic [WORD-1:0] rdata, input logic rfwe, input logic src,
                        input int rd, input int d, input string tag);
    bit mem, mis, go, tmo, in_req, in_wait, exp_valid, exp_fault;
    int n;
    mem = (kind == K_LOAD) || (kind == K_STORE);
    mis = mem && (alu[1:0] != 2'b00);
    go  = mem && !mis;
    tmo = go && (kind == K_LOAD) && (d >= TIMEOUT);
    if (!go)                 n = 1;
    else if (kind == K_STORE) n = 2 + rd;
    else                     n = 3 + rd + ((d < TIMEOUT) ? d : TIMEOUT - 1);

    is_valid_i     = (kind != K_BUBBLE);
    mem_read_en_i  = (kind == K_LOAD || (kind != K_ALU && $urandom_range(0, 1) == 1))
                     ? MEM_READ : MEM_READ_DISABLE;
    mem_write_en_i = (kind == K_STORE) ? MEM_WRITE : MEM_WRITE_DISABLE;
    reg_file_write_en_i    = rfwe ? WRITE : NO_WRITE;
    reg_file_data_source_i = src ? DATA_FROM_MEM : DATA_FROM_ALU;
    reg_dest_addr_i = dest;
    alu_result_i    = alu;
    reg_2_data_i    = wdata;

    for (int k = 0; k < n; k++) begin
      in_req  = go && (k >= 1) && (k <= 1 + rd);
      in_wait = go && (kind == K_LOAD) && (k >= 2 + rd);
      dmem_ready_i  = in_req && (k == 1 + rd);
      dmem_rvalid_i = in_wait ? (!tmo && k == 2 + rd + d) : ($urandom_range(0, 1) == 1);
      dmem_rdata_i  = (in_wait && dmem_rvalid_i) ? rdata : $urandom;
      #1;
      check($sformatf("%s stall k=%0d", tag, k), stall_o, (k != n - 1));
      check($sformatf("%s req k=%0d", tag, k), dmem_req_o, in_req);
      if (in_req) begin
        check($sformatf("%s addr k=%0d", tag, k), dmem_addr_o, alu);
        check($sformatf("%s we k=%0d", tag, k), dmem_we_o, (kind == K_STORE));
        if (kind == K_STORE) check($sformatf("%s wdata k=%0d", tag, k), dmem_wdata_o, wdata);
      end
      if (k >= 1) begin
        check($sformatf("%s bubble k=%0d", tag, k), is_valid_o, 1'b0);
        check($sformatf("%s nofault k=%0d", tag, k), fault_o, 1'b0);
      end
      next_cycle();
    end
    dmem_ready_i  = 1'b0;
    dmem_rvalid_i = 1'b0;

    exp_valid = (kind == K_ALU) || (go && !tmo);
    exp_fault = mis || tmo;
    check({tag, " valid"}, is_valid_o, exp_valid);
    check({tag, " fault"}, fault_o, exp_fault);
    check({tag, " rf_we"}, (reg_file_write_en_o == WRITE), exp_valid && rfwe);
    if (exp_valid) begin
      check({tag, " dest"}, reg_dest_addr_o, dest);
      if (kind != K_STORE)
        check({tag, " data"}, reg_data_o, (kind == K_LOAD && src) ? rdata : alu);
    end
  endtask

  initial begin
    kind_e            kind;
    logic [WORD-1:0]  alu;
    int               d;

    #1;
    check("reset stall", stall_o, 1'b0);
    check("reset req", dmem_req_o, 1'b0);
    check("reset valid", is_valid_o, 1'b0);
    check("reset fault", fault_o, 1'b0);
    check("reset rf_we", (reg_file_write_en_o == WRITE), 1'b0);
    check("reset dest", reg_dest_addr_o, 0);
    check("reset data", reg_data_o, 0);
    next_cycle();
    reset_i = 1'b1;
    next_cycle();

    run_op(K_ALU,   5'd5, 32'h0000_1234, '0, '0, 1'b1, 1'b0, 0, 0, "alu_1234");
    run_op(K_STORE, 5'd3, 32'h0000_0100, 32'hDEAD_BEEF, '0, 1'b0, 1'b0, 2, 0, "store_100");
    run_op(K_LOAD,  5'd9, 32'h0000_0200, '0, 32'hCAFE_F00D, 1'b1, 1'b1, 0, 2, "load_200");
    run_op(K_BUBBLE, 5'd0, '0, '0, '0, 1'b0, 1'b0, 0, 0, "after_load");
    run_op(K_LOAD,  5'd4, 32'h0000_0203, '0, '0, 1'b1, 1'b1, 0, 0, "load_203");
    run_op(K_BUBBLE, 5'd0, '0, '0, '0, 1'b0, 1'b0, 0, 0, "after_misaligned");
    run_op(K_LOAD,  5'd6, 32'h0000_0040, '0, 32'h1111_2222, 1'b1, 1'b1, 1, 30, "load_timeout");
    run_op(K_LOAD,  5'd6, 32'h0000_0044, '0, 32'h3333_4444, 1'b1, 1'b1, 0, 15, "load_rvalid_16");
    run_op(K_LOAD,  5'd8, 32'h0000_0048, '0, 32'h5555_6666, 1'b1, 1'b0, 0, 1, "load_alu_src");

    for (int i = 0; i < 60; i++) begin
      kind = kind_e'($urandom_range(0, 3));
      alu  = $urandom;
      if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      run_op(kind, 5'($urandom), alu, $urandom, $urandom, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), d, $sformatf("rand%0d", i));
    end

    // Reset asserted while a load sits in WAIT.
    is_valid_i = 1'b1;
    mem_read_en_i = MEM_READ;
    mem_write_en_i = MEM_WRITE_DISABLE;
    reg_file_write_en_i = WRITE;
    reg_file_data_source_i = DATA_FROM_MEM;
    reg_dest_addr_i = 5'd7;
    alu_result_i = 32'h0000_0300;
    next_cycle();
    dmem_ready_i = 1'b1;
    next_cycle();
    dmem_ready_i = 1'b0;
    next_cycle();
    check("wait stall before reset", stall_o, 1'b1);
    #2;
    reset_i = 1'b0;
    #1;
    check("midreset stall", stall_o, 1'b0);
    check("midreset req", dmem_req_o, 1'b0);
    check("midreset addr", dmem_addr_o, 0);
    check("midreset valid", is_valid_o, 1'b0);
    check("midreset fault", fault_o, 1'b0);
    check("midreset rf_we", (reg_file_write_en_o == WRITE), 1'b0);
    check("midreset dest", reg_dest_addr_o, 0);
    check("midreset data", reg_data_o, 0);
    is_valid_i = 1'b0;
    mem_read_en_i = MEM_READ_DISABLE;
    next_cycle();
    reset_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hBAD0_BAD0;
    #1;
    check("late rvalid stall", stall_o, 1'b0);
    next_cycle();
    dmem_rvalid_i = 1'b0;
    check("late rvalid valid", is_valid_o, 1'b0);
    check("late rvalid fault", fault_o, 1'b0);
    run_op(K_ALU, 5'd12, 32'h0000_ABCD, '0, '0, 1'b1, 1'b0, 0, 0, "alu_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
